tim_apb_arb: RTL and testbench
==============================

// Module: tim_apb_arb
// PURPOSE
//  APB master front-end for timer_top: arbitrates two command requesters (req0 = CPU bridge,
//  req1 = config/boot sequencer) round-robin, runs one APB SETUP/ACCESS transfer per command on
//  the tim_p* bus, returns read data/error to the winning requester. Adds access timeout and
//  misalignment rejection. Sits between system-side masters and the timer_top slave.
// PARAMETERS
//  ADDR_W   12  APB address width (matches tim_paddr)
//  DATA_W   32  APB data width; strobe width = DATA_W/8
//  TIMEOUT  16  max ACCESS cycles waiting for tim_pready; 0 = no timeout
// PORTS
//  sys_clk      in   1       single clock, all logic rising-edge
//  sys_rst      in   1       synchronous, active-high reset
//  cmdN_valid   in   1       N=0,1: command present
//  cmdN_ready   out  1       N=0,1: command accepted this cycle (valid&ready)
//  cmdN_write   in   1       1=write, 0=read
//  cmdN_addr    in   ADDR_W  byte address
//  cmdN_wdata   in   DATA_W  write data
//  cmdN_strb    in   DATA_W/8 byte strobes (writes only)
//  rspN_valid   out  1       one-cycle response pulse, no backpressure
//  rspN_rdata   out  DATA_W  read data; 0 for writes/errors
//  rspN_err     out  1       pslverr, timeout or misaligned
//  rspN_tmo     out  1       error was timeout
//  tim_psel/tim_penable/tim_pwrite out 1; tim_paddr out ADDR_W; tim_pwdata out DATA_W; tim_pstrb out DATA_W/8
//  tim_prdata   in   DATA_W; tim_pready in 1; tim_pslverr in 1
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (psel, penable, rsp*_valid, cmd*_ready, data/addr regs);
//    last_grant=1 so req0 wins first contention. Reset mid-transfer aborts: psel/penable low after
//    the reset edge, no response issued, command lost.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. cmdN_ready only in IDLE, combinational, to winner only.
//  - Arbitration in IDLE: one valid -> it wins; both valid -> requester != last_grant wins;
//    last_grant updates on acceptance only.
//  - Accept (cycle T): latch write/addr/wdata/strb and grant id. If addr[1:0]!=0: no APB cycle,
//    stay IDLE, rsp valid at T+1 with err=1, tmo=0, rdata=0; ready held low that one cycle.
//  - SETUP (T+1): psel=1, penable=0, address/control/data stable. tim_pstrb=0 for reads.
//  - ACCESS (T+2..): psel=1, penable=1, all signals held until tim_pready=1 sampled.
//  - Completion on pready: rsp of granted id valid next cycle; rdata=tim_prdata for reads else 0;
//    err=tim_pslverr. Zero-wait best case: accept T, rsp T+3, next accept T+3 (back-to-back ok).
//  - Timeout: ACCESS cycle counter (width clog2(TIMEOUT+1)) starts at 1; when it equals TIMEOUT with
//    pready=0 -> psel/penable drop next cycle, rsp err=1, tmo=1, rdata=0. pready on the same cycle
//    as the limit wins (normal completion).
//  - Only rsp of granted id pulses; other rsp stays 0. Only one outstanding transfer ever.
//  - cmd inputs ignored outside acceptance; changing valid/fields while not ready is harmless.
// STRUCTURE
//  - tim_apb_pkg: state enum {IDLE,SETUP,ACCESS}, cmd struct {write,addr,wdata,strb},
//    APB_ALIGN_MASK constant.
//  - Sub-module tim_rr_arb2: 2-way round-robin (req[1:0], accept, last_grant reg -> gnt[1:0]).
//  - Top holds FSM, command latch, timeout counter, response registers.
// TESTING
//  1. Reset release, cmd0 write addr 0x000 data 0x0000_0003 strb 0xF, slave pready in ACCESS
//     -> psel T+1, penable T+2, rsp0_valid T+3 err=0 rdata=0; rsp1_valid never asserted.
//  2. cmd0 and cmd1 valid continuously, reads 0x004/0x008 -> grants alternate 0,1,0,1;
//     each rsp carries tim_prdata of its own transfer.
//  3. Slave pready delayed 3 ACCESS cycles on read 0x00C returning 0xDEAD_BEEF -> all APB signals
//     stable throughout; rsp valid one cycle after pready with rdata 0xDEAD_BEEF.
//  4. TIMEOUT=16, pready held low -> after 16 ACCESS cycles psel drops, rsp err=1 tmo=1 rdata=0;
//     then variant with pready on 16th cycle -> normal completion, tmo=0.
//  5. cmd1 addr 0x006 -> no psel pulse, rsp1_valid next cycle err=1 tmo=0; tim_pslverr=1 from
//     slave on a valid access -> err=1 tmo=0.
//  6. sys_rst asserted during ACCESS -> psel/penable 0 after edge, no rsp pulse, next contention
//     after release grants req0.

Source files
------------

// File: rtl/tim_apb_pkg.sv
`default_nettype none
// ============================================================================
// tim_apb_pkg : shared types for the timer APB master front-end
// Revision    : 1.0
// ============================================================================
package tim_apb_pkg;

    localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

    localparam int CMD_ADDR_W = 12;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_W-1:0]     addr;
        logic [CMD_DATA_W-1:0]     wdata;
        logic [CMD_DATA_W/8-1:0]   strb;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/tim_rr_arb2.sv
`default_nettype none
// ============================================================================
// tim_rr_arb2 : two-way round-robin arbiter, grant history advances on accept
// Revision    : 1.0
// ============================================================================
module tim_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_last;

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_gnt[1];
        end
    end

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tim_apb_arb.sv
`default_nettype none
// ============================================================================
// tim_apb_arb : two-requester APB master for timer_top with timeout and
//               misalignment rejection
// Revision    : 1.0
// ============================================================================
module tim_apb_arb
    import tim_apb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd0_valid,
    output logic                cmd0_ready,
    input  logic                cmd0_write,
    input  logic [ADDR_W-1:0]   cmd0_addr,
    input  logic [DATA_W-1:0]   cmd0_wdata,
    input  logic [DATA_W/8-1:0] cmd0_strb,
    input  logic                cmd1_valid,
    output logic                cmd1_ready,
    input  logic                cmd1_write,
    input  logic [ADDR_W-1:0]   cmd1_addr,
    input  logic [DATA_W-1:0]   cmd1_wdata,
    input  logic [DATA_W/8-1:0] cmd1_strb,
    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_rdata,
    output logic                rsp0_err,
    output logic                rsp0_tmo,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_rdata,
    output logic                rsp1_err,
    output logic                rsp1_tmo,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pready,
    input  logic                tim_pslverr
);

    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);
    localparam bit              C_TMO_EN = (TIMEOUT != 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_misalign;
    logic              w_done;
    logic              w_tmo;
    logic              r_blk;
    logic              r_id;
    cmd_t              w_cmd;
    cmd_t              r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_tmo;

    assign w_req = {cmd1_valid, cmd0_valid};

    tim_rr_arb2 u_arb (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_req    (w_req),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // Ready is also withheld for the cycle a misaligned reject is answered.
    assign cmd0_ready = (r_state == IDLE) && !r_blk && w_gnt[0];
    assign cmd1_ready = (r_state == IDLE) && !r_blk && w_gnt[1];
    assign w_accept   = cmd0_ready || cmd1_ready;

    always_comb begin
        w_cmd.write = w_gnt[1] ? cmd1_write : cmd0_write;
        w_cmd.addr  = w_gnt[1] ? cmd1_addr  : cmd0_addr;
        w_cmd.wdata = w_gnt[1] ? cmd1_wdata : cmd0_wdata;
        w_cmd.strb  = w_gnt[1] ? cmd1_strb  : cmd0_strb;
        if (!w_cmd.write) begin
            w_cmd.strb = '0;
        end
    end

    assign w_misalign = |(w_cmd.addr[1:0] & APB_ALIGN_MASK);
    assign w_done     = (r_state == ACCESS) && tim_pready;
    assign w_tmo      = (r_state == ACCESS) && !tim_pready && C_TMO_EN && (r_cnt == C_LIMIT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_misalign) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_done || w_tmo) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tim_psel    = (r_state != IDLE);
        tim_penable = (r_state == ACCESS);
    end

    assign tim_pwrite = r_cmd.write;
    assign tim_paddr  = r_cmd.addr;
    assign tim_pwdata = r_cmd.wdata;
    assign tim_pstrb  = r_cmd.strb;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cmd       <= '0;
            r_id        <= 1'b0;
            r_blk       <= 1'b0;
            r_cnt       <= '0;
            r_rsp_vld   <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_blk       <= 1'b0;
            r_rsp_vld   <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            if (r_state == SETUP) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_id <= w_gnt[1];
                if (w_misalign) begin
                    r_blk     <= 1'b1;
                    r_rsp_vld <= w_gnt;
                    r_rsp_err <= 1'b1;
                end else begin
                    r_cmd <= w_cmd;
                end
            end
            if (w_done) begin
                r_rsp_vld   <= r_id ? 2'b10 : 2'b01;
                r_rsp_err   <= tim_pslverr;
                r_rsp_rdata <= (r_cmd.write || tim_pslverr) ? '0 : tim_prdata;
            end else if (w_tmo) begin
                r_rsp_vld <= r_id ? 2'b10 : 2'b01;
                r_rsp_err <= 1'b1;
                r_rsp_tmo <= 1'b1;
            end
        end
    end

    assign rsp0_valid = r_rsp_vld[0];
    assign rsp0_rdata = r_rsp_vld[0] ? r_rsp_rdata : '0;
    assign rsp0_err   = r_rsp_vld[0] && r_rsp_err;
    assign rsp0_tmo   = r_rsp_vld[0] && r_rsp_tmo;
    assign rsp1_valid = r_rsp_vld[1];
    assign rsp1_rdata = r_rsp_vld[1] ? r_rsp_rdata : '0;
    assign rsp1_err   = r_rsp_vld[1] && r_rsp_err;
    assign rsp1_tmo   = r_rsp_vld[1] && r_rsp_tmo;

endmodule
`default_nettype wire

// File: tb/tb_tim_apb_arb.sv
`default_nettype none
// ============================================================================
// tb_tim_apb_arb : directed + randomized bench for tim_apb_arb
// Revision       : 1.0
// ============================================================================
module tb_tim_apb_arb;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd0_valid = 1'b0, cmd1_valid = 1'b0;
    logic        cmd0_ready, cmd1_ready;
    logic        cmd0_write = 1'b0, cmd1_write = 1'b0;
    logic [11:0] cmd0_addr = '0, cmd1_addr = '0;
    logic [31:0] cmd0_wdata = '0, cmd1_wdata = '0;
    logic [3:0]  cmd0_strb = '0, cmd1_strb = '0;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_tmo, rsp1_tmo;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata, tim_prdata;
    logic [3:0]  tim_pstrb;

    int          n_chk = 0;
    int          n_err = 0;
    int          m_last = 1;
    int          acc_seen = 0;
    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;

    always #5 clk = ~clk;

    tim_apb_arb #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_write(cmd0_write),
        .cmd0_addr(cmd0_addr), .cmd0_wdata(cmd0_wdata), .cmd0_strb(cmd0_strb),
        .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_write(cmd1_write),
        .cmd1_addr(cmd1_addr), .cmd1_wdata(cmd1_wdata), .cmd1_strb(cmd1_strb),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err), .rsp0_tmo(rsp0_tmo),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err), .rsp1_tmo(rsp1_tmo),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
    );

    // Slave: raises pready after slv_wait stalled ACCESS cycles.
    assign tim_pready  = tim_psel && tim_penable && (acc_seen == slv_wait);
    assign tim_prdata  = slv_rdata;
    assign tim_pslverr = slv_err && tim_pready;

    always @(posedge clk) begin
        if (tim_psel && tim_penable && !tim_pready) acc_seen <= acc_seen + 1;
        else acc_seen <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        if (id == 0) begin
            cmd0_write = wr; cmd0_addr = a; cmd0_wdata = wd; cmd0_strb = st;
        end else begin
            cmd1_write = wr; cmd1_addr = a; cmd1_wdata = wd; cmd1_strb = st;
        end
        cmd0_valid = (id == 0);
        cmd1_valid = (id == 1);
        #1;
    endtask

    // Called at a sampling point where the DUT can accept; returns at the
    // sampling point of the first cycle it can accept again.
    task automatic run_xfer(input int id, input logic wr, input logic [11:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            input int wt, input logic [31:0] rd, input logic se);
        logic mis, tmo_exp;
        int   lat;
        mis     = (a[1:0] != 2'b00);
        tmo_exp = (wt >= TIMEOUT);
        lat     = tmo_exp ? 2 + TIMEOUT : 3 + wt;
        slv_wait = wt; slv_rdata = rd; slv_err = se;
        chk("ready_winner", (id == 0) ? cmd0_ready : cmd1_ready, 1);
        chk("ready_loser",  (id == 0) ? cmd1_ready : cmd0_ready, 0);
        m_last = id;
        @(posedge clk);
        if (mis) begin
            @(negedge clk);
            chk("mis_psel", tim_psel, 0);
            chk("mis_rsp_win", (id == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("mis_rsp_other", (id == 0) ? rsp1_valid : rsp0_valid, 0);
            chk("mis_err", (id == 0) ? rsp0_err : rsp1_err, 1);
            chk("mis_tmo", (id == 0) ? rsp0_tmo : rsp1_tmo, 0);
            chk("mis_rdata", (id == 0) ? rsp0_rdata : rsp1_rdata, 0);
            chk("mis_ready_low", cmd0_ready | cmd1_ready, 0);
            @(negedge clk);
            chk("mis_psel2", tim_psel, 0);
            chk("mis_rsp_once", rsp0_valid | rsp1_valid, 0);
        end else begin
            for (int c = 1; c < lat; c++) begin
                @(negedge clk);
                chk("bus_psel", tim_psel, 1);
                chk("bus_penable", tim_penable, (c >= 2));
                chk("bus_pwrite", tim_pwrite, wr);
                chk("bus_paddr", tim_paddr, a);
                if (wr) chk("bus_pwdata", tim_pwdata, wd);
                chk("bus_pstrb", tim_pstrb, wr ? st : 4'h0);
                chk("bus_no_rsp", rsp0_valid | rsp1_valid, 0);
            end
            @(negedge clk);
            chk("end_psel", tim_psel, 0);
            chk("end_penable", tim_penable, 0);
            chk("rsp_win", (id == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("rsp_other", (id == 0) ? rsp1_valid : rsp0_valid, 0);
            chk("rsp_rdata", (id == 0) ? rsp0_rdata : rsp1_rdata,
                (wr || se || tmo_exp) ? 32'h0 : rd);
            chk("rsp_err", (id == 0) ? rsp0_err : rsp1_err, tmo_exp ? 1'b1 : se);
            chk("rsp_tmo", (id == 0) ? rsp0_tmo : rsp1_tmo, tmo_exp);
        end
    endtask

    initial begin
        logic [11:0] a;
        int          id, wt;
        logic        wr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", tim_psel, 0);
        chk("rst_penable", tim_penable, 0);
        chk("rst_paddr", tim_paddr, 0);
        chk("rst_pwdata", tim_pwdata, 0);
        chk("rst_rsp", rsp0_valid | rsp1_valid, 0);
        chk("rst_ready", cmd0_ready | cmd1_ready, 0);
        rst = 1'b0;

        // Zero-wait write from requester 0
        drive(0, 1'b1, 12'h000, 32'h0000_0003, 4'hF);
        run_xfer(0, 1'b1, 12'h000, 32'h0000_0003, 4'hF, 0, 32'h1234_5678, 1'b0);
        cmd0_valid = 1'b0;

        // Continuous contention, back-to-back reads
        cmd0_write = 1'b0; cmd0_addr = 12'h004; cmd0_strb = 4'hF;
        cmd1_write = 1'b0; cmd1_addr = 12'h008; cmd1_strb = 4'h3;
        cmd0_valid = 1'b1; cmd1_valid = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            id = (m_last == 1) ? 0 : 1;
            run_xfer(id, 1'b0, (id == 1) ? 12'h008 : 12'h004, 32'h0, 4'h0, 0, $urandom, 1'b0);
        end
        cmd0_valid = 1'b0; cmd1_valid = 1'b0;

        // Wait states on a read
        drive(1, 1'b0, 12'h00C, 32'h0, 4'h0);
        run_xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // Timeout, then pready exactly on the limit cycle
        drive(0, 1'b0, 12'h020, 32'h0, 4'h0);
        run_xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 1000, 32'hAAAA_5555, 1'b0);
        drive(0, 1'b0, 12'h024, 32'h0, 4'h0);
        run_xfer(0, 1'b0, 12'h024, 32'h0, 4'h0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);

        // Misaligned reject and slave error
        drive(1, 1'b1, 12'h006, 32'h1111_2222, 4'hF);
        run_xfer(1, 1'b1, 12'h006, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0);
        drive(0, 1'b0, 12'h030, 32'h0, 4'h0);
        run_xfer(0, 1'b0, 12'h030, 32'h0, 4'h0, 1, 32'h7777_8888, 1'b1);

        // Randomized single-requester traffic
        for (int i = 0; i < 20; i++) begin
            id = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
            wt = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 4);
            drive(id, wr, a, $urandom, 4'($urandom));
            run_xfer(id, wr, a, (id == 0) ? cmd0_wdata : cmd1_wdata,
                     (id == 0) ? cmd0_strb : cmd1_strb, wt, $urandom,
                     ($urandom_range(0, 4) == 0));
            cmd0_valid = 1'b0; cmd1_valid = 1'b0;
        end

        // Reset during ACCESS, on the cycle the slave completes
        drive(1, 1'b0, 12'h040, 32'h0, 4'h0);
        slv_wait = 1; slv_rdata = 32'h5A5A_5A5A; slv_err = 1'b0;
        chk("rstmid_ready", cmd1_ready, 1);
        @(posedge clk);
        #1 cmd1_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_setup", tim_psel, 1);
        @(negedge clk);
        chk("rstmid_access", tim_penable, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_psel", tim_psel, 0);
        chk("rstmid_penable", tim_penable, 0);
        chk("rstmid_paddr", tim_paddr, 0);
        chk("rstmid_rsp", rsp0_valid | rsp1_valid, 0);
        rst = 1'b0;
        m_last = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_quiet_rsp", rsp0_valid | rsp1_valid, 0);
            chk("rstmid_quiet_psel", tim_psel, 0);
        end
        cmd0_write = 1'b0; cmd0_addr = 12'h050;
        cmd1_write = 1'b0; cmd1_addr = 12'h054;
        cmd0_valid = 1'b1; cmd1_valid = 1'b1;
        #1;
        run_xfer((m_last == 1) ? 0 : 1, 1'b0, 12'h050, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0);
        cmd0_valid = 1'b0; cmd1_valid = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
